// File: rtl/uart_pkg.sv
// Shared UART datapath definitions: detector state encoding and report-filter modes.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_QUAL  = 2'd2
    } det_state_t;

    localparam logic [1:0] MODE_ANY = 2'b00;
    localparam logic [1:0] MODE_INC = 2'b01;
    localparam logic [1:0] MODE_DEC = 2'b10;
    localparam logic [1:0] MODE_OFF = 2'b11;

    // gt/lt are the unsigned candidate-vs-reference comparisons.
    function automatic logic mode_match(input logic [1:0] mode, input logic gt, input logic lt);
        case (mode)
            MODE_ANY: return 1'b1;
            MODE_INC: return gt;
            MODE_DEC: return lt;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_change_det_stable_cnt.sv
// Saturating qualification counter; done flags that the next increment reaches STABLE_CYC.
module stable_cnt #(
    parameter int STABLE_CYC = 4,
    parameter int CNT_W      = $clog2(STABLE_CYC + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic inc,
    output logic done
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(STABLE_CYC);

    logic [CNT_W-1:0] cnt;

    assign done = ({1'b0, cnt} + 1'b1) >= {1'b0, SAT};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (load)
            cnt <= CNT_W'(1);
        else if (inc && cnt != SAT)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/data_change_det.sv
// Debounced change detector: a new word must hold STABLE_CYC samples before it
// replaces the reference; accepted changes are reported through a mode filter.
module data_change_det
    import uart_pkg::*;
#(
    parameter int DATA_W     = 7,
    parameter int STABLE_CYC = 4,
    parameter int CNT_W      = $clog2(STABLE_CYC + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        mode_i,
    input  logic              clr_i,
    output logic              flag,
    output logic              sticky_o,
    output logic [DATA_W-1:0] prev_o,
    output logic [DATA_W-1:0] curr_o
);

    det_state_t        state;
    logic [DATA_W-1:0] ref_val;
    logic [DATA_W-1:0] cand;
    logic [DATA_W-1:0] acc_val;
    logic              cnt_clr, cnt_load, cnt_inc, cnt_done;
    logic              accept, report;

    stable_cnt #(
        .STABLE_CYC(STABLE_CYC),
        .CNT_W     (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .load(cnt_load),
        .inc (cnt_inc),
        .done(cnt_done)
    );

    // With STABLE_CYC=1 the first differing sample is accepted straight from TRACK.
    assign acc_val = (state == ST_TRACK) ? data_i : cand;
    assign report  = mode_match(mode_i, acc_val > ref_val, acc_val < ref_val);

    always_comb begin
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        accept   = 1'b0;
        if (!en) begin
            cnt_clr = 1'b1;
        end else begin
            case (state)
                ST_TRACK: begin
                    if (data_i != ref_val) begin
                        if (STABLE_CYC == 1) accept   = 1'b1;
                        else                 cnt_load = 1'b1;
                    end
                end
                ST_QUAL: begin
                    if (data_i == cand) begin
                        if (cnt_done) begin
                            accept  = 1'b1;
                            cnt_clr = 1'b1;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end else if (data_i == ref_val) begin
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_load = 1'b1;
                    end
                end
                default: cnt_clr = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_INIT;
            ref_val  <= '0;
            cand     <= '0;
            flag     <= 1'b0;
            sticky_o <= 1'b0;
            prev_o   <= '0;
            curr_o   <= '0;
        end else begin
            flag <= 1'b0;
            if (clr_i) sticky_o <= 1'b0;
            if (!en) begin
                state <= ST_INIT;
            end else begin
                case (state)
                    ST_INIT: begin
                        ref_val <= data_i;
                        curr_o  <= data_i;
                        state   <= ST_TRACK;
                    end
                    ST_TRACK: begin
                        if (data_i != ref_val) begin
                            cand  <= data_i;
                            state <= ST_QUAL;
                        end
                    end
                    ST_QUAL: begin
                        if (data_i == ref_val) state <= ST_TRACK;
                        else if (data_i != cand) cand <= data_i;
                    end
                    default: state <= ST_INIT;
                endcase
                if (accept) begin
                    prev_o  <= ref_val;
                    ref_val <= acc_val;
                    curr_o  <= acc_val;
                    state   <= ST_TRACK;
                    flag    <= report;
                    // Set beats a same-cycle clear.
                    if (report) sticky_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_change_det.sv
// Randomised and directed check of data_change_det (STABLE_CYC=4 and =1) against a run-length model.
module tb_data_change_det;

    localparam int DW = 7;
    localparam int SC [2] = '{4, 1};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [DW-1:0] data = '0;
    logic [1:0]    mode = 2'b00;
    logic          clr = 1'b0;

    logic          flag_d   [2];
    logic          sticky_d [2];
    logic [DW-1:0] prev_d   [2];
    logic [DW-1:0] curr_d   [2];

    data_change_det #(.DATA_W(DW), .STABLE_CYC(4)) u4 (
        .clk(clk), .rst(rst), .en(en), .data_i(data), .mode_i(mode), .clr_i(clr),
        .flag(flag_d[0]), .sticky_o(sticky_d[0]), .prev_o(prev_d[0]), .curr_o(curr_d[0]));

    data_change_det #(.DATA_W(DW), .STABLE_CYC(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .data_i(data), .mode_i(mode), .clr_i(clr),
        .flag(flag_d[1]), .sticky_o(sticky_d[1]), .prev_o(prev_d[1]), .curr_o(curr_d[1]));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Model: reference valid bit, reference, and the current run of equal differing samples.
    bit            m_valid [2];
    logic [DW-1:0] m_ref   [2];
    logic [DW-1:0] m_run_v [2];
    int            m_run   [2];
    bit            m_flag  [2];
    bit            m_sticky[2];
    logic [DW-1:0] m_prev  [2];
    logic [DW-1:0] m_curr  [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0; m_ref[i] = '0; m_run_v[i] = '0; m_run[i] = 0;
            m_flag[i] = 0; m_sticky[i] = 0; m_prev[i] = '0; m_curr[i] = '0;
        end
    endtask

    task automatic model_step();
        bit rep;
        for (int i = 0; i < 2; i++) begin
            m_flag[i] = 0;
            if (clr) m_sticky[i] = 0;
            if (!en) begin
                m_valid[i] = 0;
                m_run[i]   = 0;
            end else if (!m_valid[i]) begin
                m_valid[i] = 1;
                m_ref[i]   = data;
                m_curr[i]  = data;
                m_run[i]   = 0;
            end else if (data == m_ref[i]) begin
                m_run[i] = 0;
            end else begin
                if (m_run[i] > 0 && data == m_run_v[i]) m_run[i]++;
                else begin m_run_v[i] = data; m_run[i] = 1; end
                if (m_run[i] >= SC[i]) begin
                    case (mode)
                        2'b00: rep = 1;
                        2'b01: rep = (m_run_v[i] > m_ref[i]);
                        2'b10: rep = (m_run_v[i] < m_ref[i]);
                        default: rep = 0;
                    endcase
                    m_prev[i] = m_ref[i];
                    m_ref[i]  = m_run_v[i];
                    m_curr[i] = m_run_v[i];
                    m_run[i]  = 0;
                    m_flag[i] = rep;
                    if (rep) m_sticky[i] = 1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("flag[S=%0d]", SC[i]),   32'(flag_d[i]),   32'(m_flag[i]));
                chk($sformatf("sticky[S=%0d]", SC[i]), 32'(sticky_d[i]), 32'(m_sticky[i]));
                chk($sformatf("prev[S=%0d]", SC[i]),   32'(prev_d[i]),   32'(m_prev[i]));
                chk($sformatf("curr[S=%0d]", SC[i]),   32'(curr_d[i]),   32'(m_curr[i]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
    endtask

    task automatic cyc(input logic [DW-1:0] d, input int n = 1);
        for (int k = 0; k < n; k++) begin
            data = d;
            step();
        end
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_flag",   32'(flag_d[0]),   0);
        chk("rst_sticky", 32'(sticky_d[0]), 0);
        chk("rst_prev",   32'(prev_d[0]),   0);
        chk("rst_curr",   32'(curr_d[0]),   0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [DW-1:0] pool [4];

    initial begin
        model_reset();
        chk_on = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;

        // Reset/INIT, then mid-run reset
        cyc(7'h12, 3);
        chk("init_curr", 32'(curr_d[0]), 32'h12);
        cyc(7'h35, 2);
        pulse_reset();
        cyc(7'h12, 3);
        chk("reinit_curr", 32'(curr_d[0]), 32'h12);

        // Qualified change: flag 3 edges after first 0x35 (S=4), immediately for S=1
        cyc(7'h35);
        chk("s1_flag", 32'(flag_d[1]), 1);
        chk("s4_early", 32'(flag_d[0]), 0);
        cyc(7'h35, 2);
        chk("s4_noflag_k2", 32'(flag_d[0]), 0);
        cyc(7'h35);
        chk("s4_flag", 32'(flag_d[0]), 1);
        chk("s4_prev", 32'(prev_d[0]), 32'h12);
        chk("s4_curr", 32'(curr_d[0]), 32'h35);
        chk("s4_sticky", 32'(sticky_d[0]), 1);
        cyc(7'h35);
        chk("s4_pulse_once", 32'(flag_d[0]), 0);

        // Glitch back to reference: no flag
        clr = 1'b1; cyc(7'h35); clr = 1'b0;
        cyc(7'h12, 2);
        cyc(7'h35, 2);
        chk("glitch_curr", 32'(curr_d[0]), 32'h35);
        chk("glitch_sticky", 32'(sticky_d[0]), 0);
        // Restart on a third value, counted from its first sample
        cyc(7'h12, 2);
        cyc(7'h40, 3);
        chk("restart_early", 32'(flag_d[0]), 0);
        cyc(7'h40);
        chk("restart_flag", 32'(flag_d[0]), 1);
        chk("restart_curr", 32'(curr_d[0]), 32'h40);

        // Direction modes
        mode = 2'b01; clr = 1'b1; cyc(7'h40); clr = 1'b0;
        cyc(7'h10, 4);
        chk("inc_down_curr", 32'(curr_d[0]), 32'h10);
        chk("inc_down_sticky", 32'(sticky_d[0]), 0);
        cyc(7'h7F, 4);
        chk("inc_up_flag", 32'(flag_d[0]), 1);
        mode = 2'b11;
        cyc(7'h05, 4);
        chk("off_curr", 32'(curr_d[0]), 32'h05);
        chk("off_flag", 32'(flag_d[0]), 0);

        // Sticky set/clear race
        mode = 2'b00; clr = 1'b1; cyc(7'h05); clr = 1'b0;
        cyc(7'h22, 3);
        clr = 1'b1; cyc(7'h22);
        chk("race_sticky", 32'(sticky_d[0]), 1);
        cyc(7'h22);
        chk("race_cleared", 32'(sticky_d[0]), 0);
        clr = 1'b0;

        // Enable drop mid-qualification, then reload without flag
        cyc(7'h22);
        cyc(7'h33, 2);
        en = 1'b0;
        cyc(7'h33, 2);
        chk("en0_curr", 32'(curr_d[0]), 32'h22);
        chk("en0_flag", 32'(flag_d[0]), 0);
        en = 1'b1;
        cyc(7'h44);
        chk("reen_curr", 32'(curr_d[0]), 32'h44);
        chk("reen_flag", 32'(flag_d[0]), 0);

        // Randomised run over a small value pool so runs, glitches and restarts occur often
        for (int k = 0; k < 4; k++) pool[k] = 7'($urandom);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
                continue;
            end
            if ($urandom_range(0, 99) == 0) pool[$urandom_range(0, 3)] = 7'($urandom);
            if ($urandom_range(0, 2) == 0) data = pool[$urandom_range(0, 3)];
            en   = ($urandom_range(0, 19) != 0);
            clr  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
            step();
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_change_det.md
# data_change_det

Parametrised, debounced change detector for parallel data words in the UART datapath, for example received characters or status fields. It holds a reference value, requires a new value to be stable for `STABLE_CYC` consecutive samples before accepting it, and then reports the change. Reporting is a one-cycle pulse plus a sticky flag, filtered by a direction mode. The block sits after the UART receive register and feeds control/status logic.

## Interface
Parameters:
- `DATA_W`, 7: data word width, 1..32.
- `STABLE_CYC`, 4: consecutive equal samples needed to accept a new value, 1..255.
- `CNT_W`, `$clog2(STABLE_CYC+1)`: qualification counter width (derived; do not override).

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: detector enable; low forces INIT.
- `data_i` in `DATA_W`: monitored word, sampled every `clk` edge while `en`=1.
- `mode_i` in 2: report filter. 00 = any change, 01 = increase only, 10 = decrease only, 11 = track without reporting.
- `clr_i` in 1: clears `sticky_o`.
- `flag` out 1: one-cycle pulse on each accepted, reportable change.
- `sticky_o` out 1: latched copy of `flag`, held until `clr_i`.
- `prev_o` out `DATA_W`: reference value before the last accepted change.
- `curr_o` out `DATA_W`: current accepted reference value.

## Operation
- States:
  - INIT: no valid reference.
  - TRACK: reference valid, input equal to it.
  - QUAL: candidate value being qualified.
- INIT, `en`=1: load `ref` ← `data_i`; `curr_o` ← `data_i`; go TRACK. No flag.
- TRACK:
  - `data_i`≠`ref`: `cand` ← `data_i`, `cnt` ← 1.
  - If `STABLE_CYC`=1, accept immediately and stay in TRACK; otherwise go QUAL.
- QUAL:
  - `data_i`==`cand`: `cnt`+1; when `cnt`+1 == `STABLE_CYC`, accept.
  - `data_i`==`ref`: glitch; drop `cand`, go TRACK, no flag.
  - Any other value: `cand` ← `data_i`, `cnt` ← 1, stay in QUAL (restart).
- Accept:
  - `prev_o` ← `ref`; `ref` and `curr_o` ← `cand`; go TRACK.
  - `flag` ← 1 if the mode matches; otherwise 0.
- Mode match:
  - 00: always.
  - 01: `cand` > `ref`, unsigned.
  - 10: `cand` < `ref`, unsigned.
  - 11: never.
- `mode_i` is sampled at the accept edge. Changing it mid-QUAL is legal.
- `sticky_o`:
  - Set on any cycle `flag` is set.
  - Cleared by `clr_i`.
  - Simultaneous set and clear: set wins.
- `en`=0:
  - Next state INIT; `cnt` ← 0; `flag` ← 0.
  - `sticky_o`, `prev_o`, `curr_o` are held.
  - Re-enable reloads the reference without flagging.
- Counter saturates at `STABLE_CYC` and never wraps.

## Timing
- Reset, asynchronous: state INIT, `cnt`=0, `flag`=0, `sticky_o`=0, `prev_o`=0, `curr_o`=0, `ref`=0, `cand`=0.
- Reset mid-QUAL aborts qualification with no flag.
- All outputs are registered; no combinational path from input to output.
- Latency: first differing sample at edge k; accept at edge k+`STABLE_CYC`−1. `flag`, `prev_o` and `curr_o` are valid after that edge.
  - Example: `STABLE_CYC`=4 gives 3 edges after the first sample.
  - `STABLE_CYC`=1: accepted at edge k.
- `flag` is high for exactly one cycle per accept.
- Back-to-back changes: the earliest next accept is `STABLE_CYC` edges after the previous one.
- Throughput: one sample per cycle, no stall and no backpressure.

## Structure
- Shared package `uart_pkg`:
  - State encodings INIT/TRACK/QUAL.
  - Mode constants `MODE_ANY`, `MODE_INC`, `MODE_DEC`, `MODE_OFF`.
- Sub-module `stable_cnt`: saturating qualification counter with load-1, increment, clear and `done` output, parametrised by `STABLE_CYC`.
- Top-level FSM, compare logic and output registers stay in `data_change_det`.

## Test plan
All scenarios use `DATA_W`=7, `STABLE_CYC`=4, `mode_i`=00 unless stated.
- Reset / INIT: assert `rst` mid-run → all outputs 0. After release with `en`=1 and `data_i`=0x12 → `curr_o`=0x12, `flag` never asserts.
- Qualified change: 0x12 steady, then 0x35 for 4 cycles → single `flag` pulse 3 edges after first 0x35. `prev_o`=0x12, `curr_o`=0x35, `sticky_o`=1.
- Glitch and restart:
  - 0x12 → 0x35 ×2 → 0x12 → no flag.
  - 0x35 ×2 → 0x40 ×4 → flag with `curr_o`=0x40, counted from first 0x40.
- Direction modes:
  - `mode_i`=01, change 0x40→0x10 → `curr_o`=0x10, no flag.
  - Then 0x10→0x7F → flag.
  - `mode_i`=11, any change → `curr_o` updates, no flag.
- Sticky / clear race: `clr_i`=1 on the same edge `flag` sets → `sticky_o`=1. `clr_i` next cycle → `sticky_o`=0.
- `STABLE_CYC`=1 and `en` drop: with `STABLE_CYC`=1, every change flags 0 edges after first sample. With `en`=0 mid-QUAL, no flag and `sticky_o` held; after re-enable the reference reloads without flag.
